// File: rtl/gray_pkg.sv
// Shared types and default widths for the Gray-code receive path.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH     = 3;
    localparam int unsigned WRAP_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_FAULT    = 2'd2
    } mon_state_t;

    // Classification of one sampled step relative to the previous sample.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_BAD  = 2'd2
    } step_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder.
module gray2bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Binary bit j is the XOR of all Gray bits from j upwards.
    always_comb begin
        bin = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            bin[j] = ^(gray >> j);
        end
    end

endmodule

// File: rtl/gray_monitor.sv
// Samples a Gray-coded count, decodes it to binary, checks that every step is
// a legal single-bit forward move, counts wraps and flags illegal steps.
module gray_monitor
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH     = GRAY_WIDTH,
    parameter int unsigned CNT_WIDTH = WRAP_CNT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Valid,
    input  logic [WIDTH-1:0]     GrayIn,
    input  logic                 Clr,
    output logic [WIDTH-1:0]     BinOut,
    output logic                 Wrap,
    output logic [CNT_WIDTH-1:0] WrapCount,
    output logic                 Locked,
    output logic                 Error
);

    mon_state_t           state;
    mon_state_t           state_nxt;
    step_t                step;

    logic [WIDTH-1:0]     prev_gray;
    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     bin_in;
    logic [WIDTH-1:0]     diff;
    logic                 single_bit;
    logic                 at_max;
    logic                 wrap_q;
    logic                 error_q;
    logic [CNT_WIDTH-1:0] wrap_cnt_q;

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_dec (
        .gray(GrayIn),
        .bin (bin_in)
    );

    // Classify the incoming sample against the last accepted one. While
    // tracking, bin_q always equals the decode of prev_gray, so it serves as
    // the previous binary value without a second decoder.
    always_comb begin
        diff       = prev_gray ^ GrayIn;
        single_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        at_max     = (bin_q == '1);
        step       = STEP_BAD;
        if (diff == '0) begin
            step = STEP_HOLD;
        end else if (single_bit && (bin_in == WIDTH'(bin_q + WIDTH'(1)))) begin
            step = STEP_FWD;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: Clr overrides any sample.
    always_comb begin
        state_nxt = state;
        if (Clr) begin
            state_nxt = ST_UNLOCKED;
        end else if (Valid) begin
            case (state)
                ST_UNLOCKED: state_nxt = ST_TRACK;
                ST_TRACK:    if (step == STEP_BAD) state_nxt = ST_FAULT;
                ST_FAULT:    state_nxt = ST_FAULT;
                default:     state_nxt = ST_UNLOCKED;
            endcase
        end
    end

    // Output decode from state.
    always_comb begin
        Locked = (state == ST_TRACK);
    end

    // Datapath registers: reference sample, binary output, wrap and error.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prev_gray  <= '0;
            bin_q      <= '0;
            wrap_q     <= 1'b0;
            error_q    <= 1'b0;
            wrap_cnt_q <= '0;
        end else if (Clr) begin
            wrap_q     <= 1'b0;
            error_q    <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (Valid) begin
                case (state)
                    ST_UNLOCKED: begin
                        prev_gray <= GrayIn;
                        bin_q     <= bin_in;
                    end
                    ST_TRACK: begin
                        if (step == STEP_FWD) begin
                            prev_gray <= GrayIn;
                            bin_q     <= bin_in;
                            if (at_max) begin
                                wrap_q <= 1'b1;
                                if (wrap_cnt_q != '1) begin
                                    wrap_cnt_q <= wrap_cnt_q + CNT_WIDTH'(1);
                                end
                            end
                        end else if (step == STEP_BAD) begin
                            prev_gray <= GrayIn;
                            bin_q     <= bin_in;
                            error_q   <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        prev_gray <= GrayIn;
                        bin_q     <= bin_in;
                    end
                    default: begin
                        prev_gray <= prev_gray;
                    end
                endcase
            end
        end
    end

    assign BinOut    = bin_q;
    assign Wrap      = wrap_q;
    assign WrapCount = wrap_cnt_q;
    assign Error     = error_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor: table vectors, hand sequences and random stimulus
// against a behavioural model. Two instances share inputs: default counter
// width and a 2-bit saturating counter.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic [2:0] GrayIn = '0;
    logic       Clr = 1'b0;

    logic [2:0] bin_a, bin_b;
    logic       wrap_a, wrap_b, lk_a, lk_b, er_a, er_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    gray_monitor #(.WIDTH(3), .CNT_WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Clr(Clr),
        .BinOut(bin_a), .Wrap(wrap_a), .WrapCount(cnt_a), .Locked(lk_a), .Error(er_a)
    );

    gray_monitor #(.WIDTH(3), .CNT_WIDTH(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn), .Clr(Clr),
        .BinOut(bin_b), .Wrap(wrap_b), .WrapCount(cnt_b), .Locked(lk_b), .Error(er_b)
    );

    // Behavioural model: plain integers, legality judged by re-encoding.
    int m_ref, m_fault, m_prevg, m_bin, m_wrap, m_wraps, m_err;

    function automatic int enc(int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int dec(int g);
        for (int b = 0; b < 8; b++) if (enc(b) == g) return b;
        return 0;
    endfunction

    task automatic model_step();
        int g;
        g = int'(GrayIn);
        if (!Reset) begin
            m_ref = 0; m_fault = 0; m_prevg = 0; m_bin = 0;
            m_wrap = 0; m_wraps = 0; m_err = 0;
        end else if (Clr) begin
            m_ref = 0; m_fault = 0; m_wrap = 0; m_wraps = 0; m_err = 0;
        end else begin
            m_wrap = 0;
            if (Valid) begin
                if (m_fault != 0) begin
                    m_prevg = g; m_bin = dec(g);
                end else if (m_ref == 0) begin
                    m_ref = 1; m_prevg = g; m_bin = dec(g);
                end else if (g == m_prevg) begin
                    m_bin = m_bin;
                end else if (g == enc((dec(m_prevg) + 1) % 8)) begin
                    if (dec(m_prevg) == 7) begin
                        m_wrap = 1; m_wraps++;
                    end
                    m_prevg = g; m_bin = dec(g);
                end else begin
                    m_fault = 1; m_err = 1; m_prevg = g; m_bin = dec(g);
                end
            end
        end
    endtask

    task automatic cmp(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check(string name, int eb, int ew, int ec, int el, int ee);
        cmp({name, " BinOut"}, int'(bin_a), eb);
        cmp({name, " Wrap"}, int'(wrap_a), ew);
        cmp({name, " WrapCount"}, int'(cnt_a), (ec > 255) ? 255 : ec);
        cmp({name, " Locked"}, int'(lk_a), el);
        cmp({name, " Error"}, int'(er_a), ee);
        cmp({name, " sat BinOut"}, int'(bin_b), eb);
        cmp({name, " sat Wrap"}, int'(wrap_b), ew);
        cmp({name, " sat WrapCount"}, int'(cnt_b), (ec > 3) ? 3 : ec);
        cmp({name, " sat Locked"}, int'(lk_b), el);
        cmp({name, " sat Error"}, int'(er_b), ee);
    endtask

    task automatic check_model(string name);
        check(name, m_bin, m_wrap, m_wraps, (m_ref != 0 && m_fault == 0) ? 1 : 0, m_err);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic rst, clr, valid;
        int   g;
        int   bin, wrap, cnt, lk, er;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic rst, logic clr, logic valid, int g,
                                int bin, int wrap, int cnt, int lk, int er);
        vec_t v;
        v.rst = rst; v.clr = clr; v.valid = valid; v.g = g;
        v.bin = bin; v.wrap = wrap; v.cnt = cnt; v.lk = lk; v.er = er;
        tbl.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        // Reset held with a sample present
        add(0, 0, 1, 5, 0, 0, 0, 0, 0);
        add(0, 0, 1, 5, 0, 0, 0, 0, 0);
        // Full legal cycle and first wrap
        add(1, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0, 0, 1, 0);
        add(1, 0, 1, 3, 2, 0, 0, 1, 0);
        add(1, 0, 1, 2, 3, 0, 0, 1, 0);
        add(1, 0, 1, 6, 4, 0, 0, 1, 0);
        add(1, 0, 1, 7, 5, 0, 0, 1, 0);
        add(1, 0, 1, 5, 6, 0, 0, 1, 0);
        add(1, 0, 1, 4, 7, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 1, 1, 0, 1, 1, 0);
        add(1, 0, 1, 3, 2, 0, 1, 1, 0);
        // Gap and repeated holds
        add(1, 0, 0, 7, 2, 0, 1, 1, 0);
        add(1, 0, 1, 3, 2, 0, 1, 1, 0);
        add(1, 0, 1, 3, 2, 0, 1, 1, 0);
        add(1, 0, 1, 2, 3, 0, 1, 1, 0);
        add(1, 0, 1, 6, 4, 0, 1, 1, 0);
        add(1, 0, 1, 7, 5, 0, 1, 1, 0);
        add(1, 0, 1, 5, 6, 0, 1, 1, 0);
        add(1, 0, 1, 4, 7, 0, 1, 1, 0);
        add(1, 0, 1, 0, 0, 1, 2, 1, 0);
        add(1, 0, 1, 1, 1, 0, 2, 1, 0);
        // 001 -> 010 two-bit change, then FAULT tracking without wraps
        add(1, 0, 1, 2, 3, 0, 2, 0, 1);
        add(1, 0, 1, 4, 7, 0, 2, 0, 1);
        add(1, 0, 1, 0, 0, 0, 2, 0, 1);
        // Clr (sample ignored, BinOut holds), relock, backward step
        add(1, 1, 1, 3, 0, 0, 0, 0, 0);
        add(1, 0, 1, 3, 2, 0, 0, 1, 0);
        add(1, 0, 1, 1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 1, 0, 0, 0, 0);
        // Mid-operation reset at BinOut=5, then relock on 110
        add(1, 0, 1, 7, 5, 0, 0, 1, 0);
        add(0, 0, 1, 5, 0, 0, 0, 0, 0);
        add(1, 0, 1, 6, 4, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            Reset  = tbl[i].rst;
            Clr    = tbl[i].clr;
            Valid  = tbl[i].valid;
            GrayIn = 3'(tbl[i].g);
            tick();
            check($sformatf("tbl[%0d]", i), tbl[i].bin, tbl[i].wrap,
                  tbl[i].cnt, tbl[i].lk, tbl[i].er);
            check_model($sformatf("tbl[%0d] model", i));
        end

        // Saturation: five full legal cycles from a fresh lock at 0
        Reset = 1'b0; Clr = 1'b0; Valid = 1'b1; GrayIn = '0;
        tick();
        Reset = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            GrayIn = 3'(enc(k % 8));
            tick();
            check_model($sformatf("sat k=%0d", k));
            if (k > 0 && k % 8 == 0) begin
                cmp($sformatf("sat wrap pulse k=%0d", k), int'(wrap_b), 1);
                cmp($sformatf("sat count k=%0d", k), int'(cnt_b), (k / 8 > 3) ? 3 : k / 8);
            end
        end

        // Gaps: inputs toggle with Valid low, everything holds
        Valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            GrayIn = 3'($urandom_range(0, 7));
            tick();
            check($sformatf("gap %0d", k), 0, 0, 5, 1, 0);
        end

        // Random stimulus, mostly legal steps, occasional clear and reset
        for (int n = 0; n < 2000; n++) begin
            int r, p;
            r = $urandom_range(0, 99);
            Reset = (r < 1) ? 1'b0 : 1'b1;
            Clr   = (r >= 1 && r < 4) ? 1'b1 : 1'b0;
            Valid = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            p = $urandom_range(0, 9);
            if (p < 6)      g = enc((dec(m_prevg) + 1) % 8);
            else if (p < 8) g = m_prevg;
            else            g = $urandom_range(0, 7);
            GrayIn = 3'(g);
            tick();
            check_model($sformatf("rand %0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
